// File: rtl/bound_pkg.sv
// Shared types and constants for the bound sequencer: state/op enums,
// table entry layout, LED width and the reset-time program.
package bound_pkg;

    localparam int LED_W    = 16;
    localparam int IDX_W    = 3;
    localparam int NUM_ENT  = 8;
    localparam int ENT_W    = 6;
    localparam int DIR_BIT  = 5;   // 1 = fill, 0 = drain
    localparam int KICK_BIT = 4;   // kick-back allowed at end of a drain
    localparam int BND_LSB  = 0;
    localparam int BND_W    = 4;

    localparam logic [IDX_W-1:0] DEF_LEN = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {HOLD, FILL, DRAIN, CLEAR} led_op_t;

    // Default program loaded on reset; unused slots are drain-to-0 entries.
    function automatic logic [ENT_W-1:0] def_entry(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    def_entry = 6'h2F;  // fill 15
            3'd1:    def_entry = 6'h15;  // drain 5, kick
            3'd2:    def_entry = 6'h2A;  // fill 10
            3'd3:    def_entry = 6'h10;  // drain 0, kick
            3'd4:    def_entry = 6'h25;  // fill 5
            default: def_entry = 6'h00;  // drain 0
        endcase
    endfunction

endpackage

// File: rtl/led_shifter.sv
// LED bar register: holds, shifts ones in from the bottom (fill),
// shifts zeros in from the top (drain) or clears.
module led_shifter
    import bound_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    output logic [LED_W-1:0] led
);

    // Apply the requested operation once per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= '0;
        end else begin
            case (led_op_t'(op))
                FILL:    led <= {led[LED_W-2:0], 1'b1};
                DRAIN:   led <= {1'b0, led[LED_W-1:1]};
                CLEAR:   led <= '0;
                default: led <= led;
            endcase
        end
    end

endmodule

// File: rtl/bound_sequencer.sv
// Runs a short program of fill/drain phases over a 16-bit LED bar. Each
// phase shifts until the LED at its bound reaches the target level; a
// drain with kick enabled may bounce back one phase while flick is high.
module bound_sequencer
    import bound_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       flick,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [5:0] cfg_data,
    input  logic       cfg_len_we,
    input  logic [2:0] cfg_len,
    output logic [15:0] led,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase,
    output logic [7:0] kick_cnt
);

    state_t           state, nstate;
    logic [IDX_W-1:0] nphase;
    logic [IDX_W-1:0] len_q;
    logic [ENT_W-1:0] tbl [NUM_ENT];
    logic [ENT_W-1:0] ent;
    logic [BND_W-1:0] bnd;
    logic             dir, kick_en, at_bound, ndone, kick_inc;
    led_op_t          op;

    assign ent      = tbl[phase];
    assign dir      = ent[DIR_BIT];
    assign kick_en  = ent[KICK_BIT];
    assign bnd      = ent[BND_LSB +: BND_W];
    // Fill is finished once the bound LED is lit, drain once it is dark.
    assign at_bound = dir ? led[bnd] : ~led[bnd];
    assign busy     = (state == RUN);

    led_shifter u_led (
        .clk (clk),
        .rst (rst),
        .op  (op),
        .led (led)
    );

    // Next-state, phase step and LED operation.
    always_comb begin
        nstate   = state;
        nphase   = phase;
        op       = HOLD;
        ndone    = 1'b0;
        kick_inc = 1'b0;
        case (state)
            IDLE: begin
                if (abort) begin
                    op = CLEAR;
                end else if (start) begin
                    nstate = RUN;
                    nphase = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    op     = CLEAR;
                    nstate = IDLE;
                    nphase = '0;
                end else if (!at_bound) begin
                    op = dir ? FILL : DRAIN;
                end else if (!dir && kick_en && flick && phase != '0) begin
                    nphase   = phase - 3'd1;
                    kick_inc = 1'b1;
                end else if (phase == len_q) begin
                    nstate = IDLE;
                    ndone  = 1'b1;
                end else begin
                    nphase = phase + 3'd1;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // Control state, done pulse and saturating kick counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            phase    <= '0;
            done     <= 1'b0;
            kick_cnt <= '0;
        end else begin
            state <= nstate;
            phase <= nphase;
            done  <= ndone;
            if (kick_inc && kick_cnt != 8'hFF)
                kick_cnt <= kick_cnt + 8'd1;
        end
    end

    // Program table and length; writable only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENT; i++)
                tbl[i] <= def_entry(IDX_W'(i));
            len_q <= DEF_LEN;
        end else if (state == IDLE) begin
            if (cfg_we)
                tbl[cfg_addr] <= cfg_data;
            if (cfg_len_we)
                len_q <= cfg_len;
        end
    end

endmodule

// File: doc/bound_sequencer.md
BOUND_SEQUENCER -- requirements
Module: bound_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst follow existing block naming.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  clock
- rst  in  1  async active-low reset
- start  in  1  begin program (sampled in IDLE only)
- abort  in  1  synchronous abort
- flick  in  1  kick-back request
- cfg_we  in  1  table write strobe
- cfg_addr  in  3  table entry index
- cfg_data  in  6  entry: [5]=dir (1 fill, 0 drain), [4]=kick_en, [3:0]=bound
- cfg_len_we  in  1  program-length write strobe
- cfg_len  in  3  last phase index
- led  out  16  LED bar
- busy  out  1  program running
- done  out  1  one-cycle completion pulse
- phase  out  3  current phase index
- kick_cnt  out  8  kick-back count, saturating

Function
REQ-003 The FSM SHALL have two states, IDLE and RUN.
REQ-004 In IDLE, start=1 at edge k SHALL give RUN, phase=0, busy=1 after edge k; led is unchanged at edge k.
REQ-005 Each RUN edge SHALL test the current phase's end condition on the pre-edge led:
- fill ends when led[bound]=1
- drain ends when led[bound]=0
REQ-006 If the end condition is not met, the block SHALL shift led:
- fill: led <= {led[14:0],1'b1}
- drain: led <= {1'b0,led[15:1]}
REQ-007 If the end condition is met, the block SHALL not shift led on that edge, and phase SHALL advance by one.
REQ-008 Kick-back: if the ending phase is a drain with kick_en=1, flick=1 and phase>0, then phase SHALL become phase-1 instead of advancing, and kick_cnt SHALL increment, saturating at 255.
REQ-009 flick SHALL be ignored in fill phases, in drain phases with kick_en=0, and in IDLE.
REQ-010 When phase=cfg_len ends without a kick-back, the FSM SHALL return to IDLE, done SHALL be 1 for exactly one cycle, busy SHALL go to 0, and led SHALL retain its value.
REQ-011 abort=1 in RUN SHALL produce led=0, IDLE, busy=0, phase=0 at the next edge, with no done pulse; abort SHALL take priority over every other RUN action.
REQ-012 abort=1 in IDLE SHALL clear led to 0.
REQ-013 start=1 while in RUN SHALL be ignored.
REQ-014 start and abort both high in IDLE: abort SHALL win and the FSM SHALL stay IDLE.
REQ-015 cfg_we and cfg_len_we SHALL write only in IDLE and SHALL be ignored in RUN.
REQ-016 A fill whose bound bit is already 1, or a drain whose bound bit is already 0, SHALL end in one edge with zero shifts.
REQ-017 A new start SHALL begin from the retained led value; led is not cleared at start.
REQ-018 kick_cnt SHALL clear only on reset.

Reset
REQ-019 rst=0 SHALL asynchronously set led=0, busy=0, done=0, phase=0, kick_cnt=0, state=IDLE.
REQ-020 Reset SHALL load the default table, cfg_len=5:
- 0: fill 15
- 1: drain 5, kick
- 2: fill 10
- 3: drain 0, kick
- 4: fill 5
- 5: drain 0
REQ-021 Reset asserted mid-RUN SHALL override all other activity, and no done pulse SHALL be produced.

Structure
REQ-022 The shared package bound_pkg SHALL hold:
- the state enum
- entry field positions and widths
- the LED width (16)
- the default table and cfg_len constant
REQ-023 The LED register and shift logic SHALL be one sub-module, led_shifter, with ops HOLD, FILL, DRAIN and CLEAR; the FSM and table SHALL stay in bound_sequencer.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Write entry0 = fill bound 3, cfg_len=0, start at edge k -> led 0001/0003/0007/000F after k+1..k+4; done=1 and busy=0 after k+5.
- Default program, flick=0 -> led reaches FFFF; drains until led[5]=0 (001F); refills to 07FF; drains to 0000; fills to 003F; drains to 0000; one done pulse; kick_cnt=0.
- Default program, flick=1 held during phase 1 -> at the phase-1 end, phase returns to 0 and kick_cnt=1; the program continues only once flick is released.
- abort during phase 2 -> led=0000, busy=0, phase=0 next cycle; no done pulse; a later start runs from phase 0.
- cfg_we during RUN with entry0 overwritten -> table unchanged; the next run repeats the default sequence.
- rst low mid-phase 3 -> all outputs 0 immediately; after release, start runs the default table.
